// File: rtl/pipe_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : pipe_hazard_ctrl
// Description : Sequencing and hazard control for a 5-stage IF/ID/EX/MEM/WB
//               LoongArch pipeline. Owns the per-stage valid bits and the
//               valid/allowin/ready_go handshake chain. Tracks the
//               destination of every in-flight instruction. Produces operand
//               forwarding selects, the load-use stall and the branch flush
//               of the instruction IF is delivering.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Parameters
//   CNT_W           width of the saturating load-use stall-cycle counter
// Ports
//   clk             clock; all state changes on the rising edge
//   reset           synchronous active-high reset
//   fs_to_ds_valid  IF presents a fetched instruction this cycle
//   ds_rj/ds_rkd    ID source register numbers
//   ds_use_rj/rkd   ID instruction really reads that source
//   ds_gr_we        ID instruction writes the register file
//   ds_dest         ID destination register
//   ds_is_load      ID instruction is a load (ld.w)
//   ds_br_taken     ID resolved a taken branch or jump
//   mem_stall       MEM data access not finished this cycle
//   fs_allowin      IF may hand an instruction to ID
//   ds/es/ms/ws_valid   stage holds a live instruction
//   ds_to_es_we / es_to_ms_we / ms_to_ws_we  pipeline register load enables
//   fwd_rj_sel/fwd_rkd_sel  0=regfile 1=EX 2=MEM 3=WB
//   br_flush        drop the instruction IF delivers; PC takes branch target
//   ws_rf_we        WB register-file write enable
//   ws_dest         WB destination register
//   stall_cnt       saturating count of load-use stall cycles
// ============================================================================
module pipe_hazard_ctrl #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             fs_to_ds_valid,
  input  logic [4:0]       ds_rj,
  input  logic [4:0]       ds_rkd,
  input  logic             ds_use_rj,
  input  logic             ds_use_rkd,
  input  logic             ds_gr_we,
  input  logic [4:0]       ds_dest,
  input  logic             ds_is_load,
  input  logic             ds_br_taken,
  input  logic             mem_stall,
  output logic             fs_allowin,
  output logic             ds_valid,
  output logic             es_valid,
  output logic             ms_valid,
  output logic             ws_valid,
  output logic             ds_to_es_we,
  output logic             es_to_ms_we,
  output logic             ms_to_ws_we,
  output logic [1:0]       fwd_rj_sel,
  output logic [1:0]       fwd_rkd_sel,
  output logic             br_flush,
  output logic             ws_rf_we,
  output logic [4:0]       ws_dest,
  output logic [CNT_W-1:0] stall_cnt
);

  localparam logic [1:0] SEL_RF  = 2'd0;
  localparam logic [1:0] SEL_EX  = 2'd1;
  localparam logic [1:0] SEL_MEM = 2'd2;
  localparam logic [1:0] SEL_WB  = 2'd3;

  // --------------------------------------------------------------------------
  // Stage state
  // --------------------------------------------------------------------------
  logic             ds_live;
  logic             es_live;
  logic             ms_live;
  logic             ws_live;

  // Destination tags that travel with each downstream instruction.
  logic             es_tag_we;
  logic [4:0]       es_tag_dest;
  logic             es_tag_load;
  logic             ms_tag_we;
  logic [4:0]       ms_tag_dest;
  logic             ws_tag_we;
  logic [4:0]       ws_tag_dest;

  logic [CNT_W-1:0] stall_count;

  // --------------------------------------------------------------------------
  // Hazard detection
  // --------------------------------------------------------------------------
  // A stage supplies a source only if it is live, writes the register file,
  // targets that register, the register is not r0 and ID actually reads it.
  function automatic logic stage_hit(
    input logic       live,
    input logic       we,
    input logic [4:0] dest,
    input logic [4:0] src,
    input logic       use_src
  );
    return live & we & (dest == src) & (src != 5'd0) & use_src;
  endfunction

  logic es_hit_rj;
  logic es_hit_rkd;
  logic ms_hit_rj;
  logic ms_hit_rkd;
  logic ws_hit_rj;
  logic ws_hit_rkd;
  logic load_use;

  assign es_hit_rj  = stage_hit(es_live, es_tag_we, es_tag_dest, ds_rj,  ds_use_rj);
  assign es_hit_rkd = stage_hit(es_live, es_tag_we, es_tag_dest, ds_rkd, ds_use_rkd);
  assign ms_hit_rj  = stage_hit(ms_live, ms_tag_we, ms_tag_dest, ds_rj,  ds_use_rj);
  assign ms_hit_rkd = stage_hit(ms_live, ms_tag_we, ms_tag_dest, ds_rkd, ds_use_rkd);
  assign ws_hit_rj  = stage_hit(ws_live, ws_tag_we, ws_tag_dest, ds_rj,  ds_use_rj);
  assign ws_hit_rkd = stage_hit(ws_live, ws_tag_we, ws_tag_dest, ds_rkd, ds_use_rkd);

  // Load data only exists after MEM, so an EX-stage load feeding ID must wait
  // one cycle; after that the load sits in MEM and forwards from there.
  assign load_use = (es_hit_rj | es_hit_rkd) & es_tag_load;

  // --------------------------------------------------------------------------
  // Handshake chain
  // --------------------------------------------------------------------------
  logic ws_allowin;
  logic ms_ready_go;
  logic ms_allowin;
  logic es_ready_go;
  logic es_allowin;
  logic ds_ready_go;
  logic ds_allowin;
  logic ds_advance;
  logic es_advance;
  logic ms_advance;
  logic flush_now;

  assign ws_allowin  = 1'b1;
  assign ms_ready_go = ~mem_stall;
  assign ms_allowin  = ~ms_live | (ms_ready_go & ws_allowin);
  assign es_ready_go = 1'b1;
  assign es_allowin  = ~es_live | ms_allowin;
  assign ds_ready_go = ~load_use;
  assign ds_allowin  = ~ds_live | (ds_ready_go & es_allowin);

  assign ds_advance  = ds_live & ds_ready_go & es_allowin;
  assign es_advance  = es_live & es_ready_go & ms_allowin;
  assign ms_advance  = ms_live & ms_ready_go & ws_allowin;

  // A branch only redirects once it actually leaves ID; a stalled branch may
  // still be waiting for its operands, so the flush is deferred with it.
  assign flush_now   = ds_advance & ds_br_taken;

  // --------------------------------------------------------------------------
  // State update
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      ds_live     <= 1'b0;
      es_live     <= 1'b0;
      ms_live     <= 1'b0;
      ws_live     <= 1'b0;
      es_tag_we   <= 1'b0;
      es_tag_dest <= 5'd0;
      es_tag_load <= 1'b0;
      ms_tag_we   <= 1'b0;
      ms_tag_dest <= 5'd0;
      ws_tag_we   <= 1'b0;
      ws_tag_dest <= 5'd0;
      stall_count <= '0;
    end else begin
      // Each stage refills only when it allows in; a stage that is not ready
      // to go while its successor accepts leaves a bubble behind.
      if (ds_allowin) ds_live <= fs_to_ds_valid & ~flush_now;
      if (es_allowin) es_live <= ds_live & ds_ready_go;
      if (ms_allowin) ms_live <= es_live & es_ready_go;
      if (ws_allowin) ws_live <= ms_live & ms_ready_go;

      if (ds_advance) begin
        es_tag_we   <= ds_gr_we;
        es_tag_dest <= ds_dest;
        es_tag_load <= ds_is_load;
      end
      if (es_advance) begin
        ms_tag_we   <= es_tag_we;
        ms_tag_dest <= es_tag_dest;
      end
      if (ms_advance) begin
        ws_tag_we   <= ms_tag_we;
        ws_tag_dest <= ms_tag_dest;
      end

      // Saturate instead of wrapping so a long run never reads as few stalls.
      if (ds_live & load_use & ~(&stall_count)) begin
        stall_count <= stall_count + {{(CNT_W-1){1'b0}}, 1'b1};
      end
    end
  end

  // --------------------------------------------------------------------------
  // Forwarding select: the youngest producer (closest to ID) wins.
  // --------------------------------------------------------------------------
  always_comb begin
    fwd_rj_sel  = SEL_RF;
    fwd_rkd_sel = SEL_RF;
    if (!reset) begin
      if (es_hit_rj)       fwd_rj_sel = SEL_EX;
      else if (ms_hit_rj)  fwd_rj_sel = SEL_MEM;
      else if (ws_hit_rj)  fwd_rj_sel = SEL_WB;

      if (es_hit_rkd)      fwd_rkd_sel = SEL_EX;
      else if (ms_hit_rkd) fwd_rkd_sel = SEL_MEM;
      else if (ws_hit_rkd) fwd_rkd_sel = SEL_WB;
    end
  end

  // --------------------------------------------------------------------------
  // Outputs. While reset is held the state may not yet be cleared, so every
  // output is forced quiet and IF is told it may deliver.
  // --------------------------------------------------------------------------
  assign fs_allowin  = reset | ds_allowin;
  assign ds_valid    = ~reset & ds_live;
  assign es_valid    = ~reset & es_live;
  assign ms_valid    = ~reset & ms_live;
  assign ws_valid    = ~reset & ws_live;
  assign ds_to_es_we = ~reset & ds_advance;
  assign es_to_ms_we = ~reset & es_advance;
  assign ms_to_ws_we = ~reset & ms_advance;
  assign br_flush    = ~reset & flush_now;
  assign ws_rf_we    = ~reset & ws_live & ws_tag_we;
  assign ws_dest     = reset ? 5'd0 : ws_tag_dest;
  assign stall_cnt   = reset ? '0 : stall_count;

endmodule
`default_nettype wire

// File: tb/tb_pipe_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_pipe_hazard_ctrl
// Description : Scoreboard bench for pipe_hazard_ctrl. A driver feeds an
//               instruction stream (directed scenarios, then random) and a
//               stage-occupancy reference model predicts every output each
//               cycle; a monitor compares the DUT against those predictions.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pipe_hazard_ctrl;

  localparam int CNT_W = 4;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             fs_to_ds_valid = 1'b0;
  logic [4:0]       ds_rj = '0;
  logic [4:0]       ds_rkd = '0;
  logic             ds_use_rj = 1'b0;
  logic             ds_use_rkd = 1'b0;
  logic             ds_gr_we = 1'b0;
  logic [4:0]       ds_dest = '0;
  logic             ds_is_load = 1'b0;
  logic             ds_br_taken = 1'b0;
  logic             mem_stall = 1'b0;
  logic             fs_allowin;
  logic             ds_valid, es_valid, ms_valid, ws_valid;
  logic             ds_to_es_we, es_to_ms_we, ms_to_ws_we;
  logic [1:0]       fwd_rj_sel, fwd_rkd_sel;
  logic             br_flush;
  logic             ws_rf_we;
  logic [4:0]       ws_dest;
  logic [CNT_W-1:0] stall_cnt;

  pipe_hazard_ctrl #(.CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .fs_to_ds_valid(fs_to_ds_valid),
    .ds_rj(ds_rj), .ds_rkd(ds_rkd), .ds_use_rj(ds_use_rj), .ds_use_rkd(ds_use_rkd),
    .ds_gr_we(ds_gr_we), .ds_dest(ds_dest), .ds_is_load(ds_is_load),
    .ds_br_taken(ds_br_taken), .mem_stall(mem_stall), .fs_allowin(fs_allowin),
    .ds_valid(ds_valid), .es_valid(es_valid), .ms_valid(ms_valid), .ws_valid(ws_valid),
    .ds_to_es_we(ds_to_es_we), .es_to_ms_we(es_to_ms_we), .ms_to_ws_we(ms_to_ws_we),
    .fwd_rj_sel(fwd_rj_sel), .fwd_rkd_sel(fwd_rkd_sel), .br_flush(br_flush),
    .ws_rf_we(ws_rf_we), .ws_dest(ws_dest), .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [4:0] rj, rkd;
    logic       urj, urk, we;
    logic [4:0] dest;
    logic       ld, br;
  } instr_t;

  typedef struct {
    bit       v, we, ld;
    bit [4:0] dest;
  } slot_t;

  typedef struct packed {
    logic             fs_allowin;
    logic             ds_v, es_v, ms_v, ws_v;
    logic             d2e, e2m, m2w;
    logic [1:0]       frj, frk;
    logic             flush;
    logic             rfwe;
    logic [4:0]       wdest;
    logic [CNT_W-1:0] cnt;
  } obs_t;

  instr_t stream[$];
  obs_t   exp_q[$];
  instr_t id_i;
  bit     id_v;
  slot_t  ex_s, mem_s, wb_s;
  int     model_cnt;
  int     checks = 0;
  int     failures = 0;
  int     cyc = 0;

  function automatic instr_t mk(logic [4:0] rj, logic [4:0] rkd, logic urj, logic urk,
                                logic we, logic [4:0] dest, logic ld, logic br);
    instr_t t;
    t.rj = rj; t.rkd = rkd; t.urj = urj; t.urk = urk;
    t.we = we; t.dest = dest; t.ld = ld; t.br = br;
    return t;
  endfunction

  function automatic instr_t rand_instr();
    return mk(5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
              1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
              1'($urandom_range(0, 4) != 0), 5'($urandom_range(0, 7)),
              1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 6) == 0));
  endfunction

  // Which in-flight stage holds the most recent writer of register s.
  function automatic logic [1:0] producer(logic [4:0] s, logic u);
    if (!u || s == 5'd0) return 2'd0;
    if (ex_s.v  && ex_s.we  && ex_s.dest  == s) return 2'd1;
    if (mem_s.v && mem_s.we && mem_s.dest == s) return 2'd2;
    if (wb_s.v  && wb_s.we  && wb_s.dest  == s) return 2'd3;
    return 2'd0;
  endfunction

  task automatic run_cycle(input bit rst, input bit fsv, input bit ms);
    obs_t  e;
    slot_t bubble;
    slot_t nx_ex, nx_mem, nx_wb;
    logic [1:0] srj, srk;
    bit lu, mem_hold, ex_stuck, id_stuck, flush, id_go;
    @(negedge clk);
    cyc++;
    reset = rst; fs_to_ds_valid = fsv; mem_stall = ms;
    ds_rj = id_i.rj; ds_rkd = id_i.rkd; ds_use_rj = id_i.urj; ds_use_rkd = id_i.urk;
    ds_gr_we = id_i.we; ds_dest = id_i.dest; ds_is_load = id_i.ld; ds_br_taken = id_i.br;
    e = '0;
    bubble = '{v: 0, we: 0, ld: 0, dest: 0};
    if (rst) begin
      e.fs_allowin = 1'b1;
      exp_q.push_back(e);
      id_v = 0; ex_s = bubble; mem_s = bubble; wb_s = bubble; model_cnt = 0;
      return;
    end
    srj = producer(id_i.rj, id_i.urj);
    srk = producer(id_i.rkd, id_i.urk);
    lu  = ex_s.ld && (srj == 2'd1 || srk == 2'd1);
    mem_hold = mem_s.v && ms;
    ex_stuck = ex_s.v && mem_hold;
    id_stuck = id_v && (lu || ex_stuck);
    id_go    = id_v && !id_stuck;
    flush    = id_go && id_i.br;
    e.fs_allowin = !id_stuck;
    e.ds_v = id_v; e.es_v = ex_s.v; e.ms_v = mem_s.v; e.ws_v = wb_s.v;
    e.d2e = id_go; e.e2m = ex_s.v && !ex_stuck; e.m2w = mem_s.v && !mem_hold;
    e.frj = srj; e.frk = srk; e.flush = flush;
    e.rfwe = wb_s.v && wb_s.we;
    e.wdest = wb_s.dest;
    e.cnt = CNT_W'(model_cnt);
    exp_q.push_back(e);

    if (id_v && lu && model_cnt < CNT_MAX) model_cnt++;
    nx_wb  = mem_hold ? bubble : mem_s;
    nx_mem = mem_hold ? mem_s : ex_s;
    if (ex_stuck)   nx_ex = ex_s;
    else if (id_go) nx_ex = '{v: 1, we: id_i.we, ld: id_i.ld, dest: id_i.dest};
    else            nx_ex = bubble;
    wb_s = nx_wb; mem_s = nx_mem; ex_s = nx_ex;
    if (!id_stuck) begin
      id_v = fsv && !flush;
      if (fsv) begin
        if (stream.size() == 0) stream.push_back(rand_instr());
        id_i = stream.pop_front();
      end
    end
  endtask

  task automatic issue(input instr_t t);
    stream.push_back(t);
    run_cycle(0, 1, 0);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) run_cycle(0, 0, 0);
  endtask

  // Monitor: compares every presented output vector against the oldest
  // prediction, well after the falling edge where inputs change.
  initial begin
    obs_t e, a;
    forever begin
      @(negedge clk);
      #2;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        a = {fs_allowin, ds_valid, es_valid, ms_valid, ws_valid,
             ds_to_es_we, es_to_ms_we, ms_to_ws_we, fwd_rj_sel, fwd_rkd_sel,
             br_flush, ws_rf_we, ws_dest, stall_cnt};
        // The WB destination only means something for a live WB instruction.
        if (!e.ws_v) begin
          e.wdest = '0;
          a.wdest = '0;
        end
        checks++;
        if (a !== e) begin
          failures++;
          $display("FAIL outputs cycle=%0d actual=%h expected=%h", cyc, a, e);
        end
      end
    end
  end

  initial begin
    id_i = rand_instr();
    id_v = 0; model_cnt = 0;
    ex_s = '{v: 0, we: 0, ld: 0, dest: 0};
    mem_s = ex_s; wb_s = ex_s;

    run_cycle(1, 0, 0);
    run_cycle(1, 0, 0);
    // Straight-line fill with add.w r4,r5,r6.
    for (int i = 0; i < 5; i++) issue(mk(5, 6, 1, 1, 1, 4, 0, 0));
    idle(5);
    // Producer/consumer at distance 1, 2 and 3.
    for (int gap = 0; gap < 3; gap++) begin
      issue(mk(5, 6, 1, 1, 1, 4, 0, 0));
      idle(gap);
      issue(mk(4, 4, 1, 1, 1, 7, 0, 0));
      idle(5);
    end
    // Load-use: ld.w r8 then add.w r9,r8,r0.
    issue(mk(1, 0, 1, 0, 1, 8, 1, 0));
    issue(mk(8, 0, 1, 1, 1, 9, 0, 0));
    idle(5);
    // Taken branch: the next IF instruction is dropped, the target follows.
    issue(mk(1, 2, 1, 1, 0, 0, 0, 1));
    issue(mk(3, 3, 1, 1, 1, 10, 0, 0));
    issue(mk(3, 3, 1, 1, 1, 11, 0, 0));
    idle(5);
    // Load-use on a branch: stall first, flush when it clears.
    issue(mk(1, 0, 1, 0, 1, 5, 1, 0));
    issue(mk(5, 5, 1, 1, 0, 0, 0, 1));
    issue(mk(2, 2, 1, 1, 1, 6, 0, 0));
    idle(5);
    // Store held in MEM for three cycles with the pipe full behind it.
    issue(mk(1, 2, 1, 1, 0, 0, 0, 0));
    issue(mk(1, 2, 1, 1, 1, 3, 0, 0));
    issue(mk(3, 2, 1, 1, 1, 4, 0, 0));
    for (int i = 0; i < 3; i++) run_cycle(0, 1, 1);
    run_cycle(0, 1, 0);
    idle(5);
    // r0 is never a forwarding source.
    issue(mk(1, 2, 1, 1, 1, 0, 1, 0));
    issue(mk(0, 0, 1, 1, 1, 12, 0, 0));
    idle(5);
    // Reset with every stage occupied.
    for (int i = 0; i < 4; i++) issue(rand_instr());
    run_cycle(1, 0, 0);
    idle(2);
    // Random traffic, including occasional resets.
    for (int i = 0; i < 3000; i++) begin
      run_cycle(1'($urandom_range(0, 399) == 0),
                1'($urandom_range(0, 9) < 8),
                1'($urandom_range(0, 3) == 0));
    end
    idle(6);
    // Drain the scoreboard within a bounded number of cycles.
    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk);
    #5;
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL drain pending=%0d required=0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
Central sequencing block for the 5-stage (IF/ID/EX/MEM/WB) LoongArch pipeline that replaces the single-cycle core.
- Owns stage valid bits and the valid/allowin/ready_go handshake chain.
- Tracks the destination register of each in-flight instruction.
- Generates forwarding selects for ID source operands, load-use stalls and branch flush of the IF instruction.
- Datapath pipeline registers load only on the enables this block issues.

Parameters:
CNT_W, 32, width of the load-use stall-cycle performance counter (saturating).

Ports:
clk  in  1  clock; all state updates on posedge
reset  in  1  synchronous, active-high reset
fs_to_ds_valid  in  1  IF presents a fetched instruction this cycle
ds_rj  in  5  ID source 1 register number
ds_rkd  in  5  ID source 2 register number (rk or rd as decoded)
ds_use_rj  in  1  ID instruction reads rj
ds_use_rkd  in  1  ID instruction reads rkd
ds_gr_we  in  1  ID instruction writes the register file
ds_dest  in  5  ID destination register (already r1 for bl)
ds_is_load  in  1  ID instruction is ld.w
ds_br_taken  in  1  ID resolved a taken branch/jump
mem_stall  in  1  MEM data access not complete this cycle
fs_allowin  out  1  IF may hand an instruction to ID
ds_valid / es_valid / ms_valid / ws_valid  out  1 each  stage holds a live instruction
ds_to_es_we / es_to_ms_we / ms_to_ws_we  out  1 each  load enable for the downstream pipeline register
fwd_rj_sel  out  2  0=regfile, 1=EX result, 2=MEM result, 3=WB result
fwd_rkd_sel  out  2  same encoding for source 2
br_flush  out  1  discard the instruction IF is delivering this cycle; PC takes the branch target
ws_rf_we  out  1  WB register-file write enable (ws_valid & ws_gr_we)
ws_dest  out  5  WB destination register
stall_cnt  out  CNT_W  count of load-use stall cycles

Behaviour:
- Reset (synchronous): all valids 0; es/ms/ws gr_we, dest and is_load regs 0; stall_cnt 0. While reset is high, all outputs are 0 except fs_allowin=1. Reset asserted mid-operation kills all in-flight instructions in the same edge.
- Handshake (combinational):
  - ws_allowin = 1.
  - ms_ready_go = !mem_stall.
  - ms_allowin = !ms_valid | (ms_ready_go & ws_allowin).
  - es_ready_go = 1.
  - es_allowin = !es_valid | ms_allowin.
  - ds_ready_go = !load_use.
  - ds_allowin = !ds_valid | (ds_ready_go & es_allowin).
  - fs_allowin = ds_allowin.
- Enables: ds_to_es_we = ds_valid & ds_ready_go & es_allowin; es_to_ms_we = es_valid & ms_allowin; ms_to_ws_we = ms_valid & ms_ready_go & ws_allowin.
- Valid updates, each only when its stage allowin is 1, otherwise hold:
  - ds_valid <= fs_to_ds_valid & !br_flush.
  - es_valid <= ds_valid & ds_ready_go.
  - ms_valid <= es_valid.
  - ws_valid <= ms_valid & ms_ready_go.
  - A stage that is not ready_go while downstream allows in inserts a bubble (valid 0).
- Per-stage gr_we/dest/is_load regs load together with their stage's enable.
- Hit rule: stage X hits source s iff X_valid & X_gr_we & X_dest==s & s!=0 & use_s.
- Forwarding: priority EX > MEM > WB; no hit gives select 0. r0 is never forwarded.
- load_use: EX hits rj or rkd AND es_is_load. This stalls ID one cycle; the next cycle the load is in MEM and MEM forwarding applies.
- br_flush = ds_valid & ds_ready_go & ds_br_taken & es_allowin. It is not asserted while ID is stalled: branch operands must be resolved first.
- Simultaneous load_use and ds_br_taken: stall wins; the flush occurs on the cycle the stall clears.
- mem_stall: MEM holds its instruction; EX and ID back-pressure via allowin; WB receives bubbles. Forwarding from a held MEM instruction remains valid.
- stall_cnt increments on every cycle with ds_valid & load_use. It saturates at all-ones and does not wrap.
- ws_rf_we is asserted only for ws_valid; write-enables from bubbles are masked.

Test Plan:
- After reset (2 cycles), drive fs_to_ds_valid=1 with add.w r4,r5,r6 each cycle -> ds/es/ms/ws_valid rise on successive cycles; ws_rf_we=1 and ws_dest=4 at cycle 4; all fwd sel 0.
- add.w r4 then add.w r7,r4,r4 back to back -> fwd_rj_sel=fwd_rkd_sel=1 in the second instruction's ID cycle. With one bubble between the two instructions -> sel=2; with two bubbles -> sel=3.
- ld.w r8 then add.w r9,r8,r0 -> ds_ready_go=0 for exactly 1 cycle; es_valid=0 bubble; next cycle fwd_rj_sel=2; stall_cnt=1.
- beq taken in ID with fs_to_ds_valid=1 -> br_flush=1 for 1 cycle; ds_valid=0 next cycle; the target instruction enters ID the cycle after.
- mem_stall=1 for 3 cycles with a store in MEM -> ms_valid held, ws_valid=0 for 3 cycles, es/ds hold and fs_allowin=0; instructions resume in order with none lost or duplicated.
- Instruction writing r0 followed by one reading r0 -> fwd sel stays 0 and no load-use stall. Asserting reset with all four stages valid -> all valids 0 after that edge.
